// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
// Holds the FSM state enum, funct3 encodings and the alignment check.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Halves need an even address, words a 4-byte aligned one.
    function automatic logic is_misaligned(
        input logic [2:0] f3,
        input logic [1:0] addr_lo
    );
        logic m;
        m = 1'b0;
        case (f3)
            F3_H, F3_HU: m = addr_lo[0];
            F3_W:        m = (addr_lo != 2'b00);
            default:     m = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment for the LSU: store replication + strobes,
// load lane select + extension. Purely combinational.
// Ports: st_* store side (live request), ld_* load side (latched
// funct3/addr_lo with the raw response word), *_o aligned results.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STRB_W = WIDTH / 8
) (
    input  logic [2:0]        st_funct3_i,
    input  logic [1:0]        st_addr_lo_i,
    input  logic [WIDTH-1:0]  st_wdata_i,
    output logic [WIDTH-1:0]  st_wdata_o,
    output logic [STRB_W-1:0] st_wstrb_o,
    input  logic [2:0]        ld_funct3_i,
    input  logic [1:0]        ld_addr_lo_i,
    input  logic [WIDTH-1:0]  ld_rdata_i,
    output logic [WIDTH-1:0]  ld_data_o
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        st_wdata_o = '0;
        st_wstrb_o = '0;
        case (st_funct3_i)
            F3_B: begin
                st_wdata_o = {4{st_wdata_i[7:0]}};
                st_wstrb_o = 4'b0001 << st_addr_lo_i;
            end
            F3_H: begin
                st_wdata_o = {2{st_wdata_i[15:0]}};
                st_wstrb_o = 4'b0011 << st_addr_lo_i;
            end
            F3_W: begin
                st_wdata_o = st_wdata_i;
                st_wstrb_o = 4'b1111;
            end
            default: begin
                st_wdata_o = '0;
                st_wstrb_o = '0;
            end
        endcase
    end

    assign ld_byte = ld_rdata_i[{ld_addr_lo_i, 3'b000} +: 8];
    assign ld_half = ld_rdata_i[{ld_addr_lo_i[1], 4'b0000} +: 16];

    always_comb begin
        ld_data_o = '0;
        case (ld_funct3_i)
            F3_B:    ld_data_o = {{(WIDTH-8){ld_byte[7]}}, ld_byte};
            F3_H:    ld_data_o = {{(WIDTH-16){ld_half[15]}}, ld_half};
            F3_BU:   ld_data_o = {{(WIDTH-8){1'b0}}, ld_byte};
            F3_HU:   ld_data_o = {{(WIDTH-16){1'b0}}, ld_half};
            F3_W:    ld_data_o = ld_rdata_i;
            default: ld_data_o = '0;
        endcase
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// Load/store unit: one valid/ready memory access per load/store,
// stalling the core until it retires. Ports: core side (mem_read,
// mem_write, funct3, addr, wdata -> stall, done, fault, rdata) and
// memory side (req_* request channel, rsp_* response channel).
module lsu_mem_stage
    import lsu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STRB_W = WIDTH / 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        funct3,
    input  logic [WIDTH-1:0]  addr,
    input  logic [WIDTH-1:0]  wdata,
    output logic              stall,
    output logic              done,
    output logic              fault,
    output logic [WIDTH-1:0]  rdata,
    output logic              req_valid,
    input  logic              req_ready,
    output logic              req_we,
    output logic [WIDTH-1:0]  req_addr,
    output logic [WIDTH-1:0]  req_wdata,
    output logic [STRB_W-1:0] req_wstrb,
    input  logic              rsp_valid,
    input  logic [WIDTH-1:0]  rsp_rdata
);

    lsu_state_t        state_q;
    logic              req_valid_q;
    logic              req_we_q;
    logic [WIDTH-1:0]  req_addr_q;
    logic [WIDTH-1:0]  req_wdata_q;
    logic [STRB_W-1:0] req_wstrb_q;
    logic [2:0]        f3_q;
    logic [1:0]        lo_q;
    logic              done_q;
    logic              fault_q;
    logic [WIDTH-1:0]  rdata_q;

    logic              access;
    logic              illegal;
    logic [WIDTH-1:0]  st_wdata;
    logic [STRB_W-1:0] st_wstrb;
    logic [WIDTH-1:0]  ld_data;

    assign access = mem_read | mem_write;

    always_comb begin
        illegal = 1'b0;
        if (mem_read && mem_write) begin
            illegal = 1'b1;
        end else if (mem_read &&
                     (funct3 == 3'b011 || funct3[2:1] == 2'b11)) begin
            illegal = 1'b1;
        end else if (mem_write && funct3 > F3_W) begin
            illegal = 1'b1;
        end else if (is_misaligned(funct3, addr[1:0])) begin
            illegal = 1'b1;
        end
    end

    lsu_align #(
        .WIDTH  (WIDTH),
        .STRB_W (STRB_W)
    ) u_align (
        .st_funct3_i  (funct3),
        .st_addr_lo_i (addr[1:0]),
        .st_wdata_i   (wdata),
        .st_wdata_o   (st_wdata),
        .st_wstrb_o   (st_wstrb),
        .ld_funct3_i  (f3_q),
        .ld_addr_lo_i (lo_q),
        .ld_rdata_i   (rsp_rdata),
        .ld_data_o    (ld_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            req_valid_q <= 1'b0;
            req_we_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_wstrb_q <= '0;
            f3_q        <= '0;
            lo_q        <= '0;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
            rdata_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (access && illegal) begin
                        // Rejected without touching the bus.
                        done_q  <= 1'b1;
                        fault_q <= 1'b1;
                        state_q <= DONE;
                    end else if (access) begin
                        req_valid_q <= 1'b1;
                        req_we_q    <= mem_write;
                        req_addr_q  <= {addr[WIDTH-1:2], 2'b00};
                        req_wdata_q <= mem_write ? st_wdata : '0;
                        req_wstrb_q <= mem_write ? st_wstrb : '0;
                        f3_q        <= funct3;
                        lo_q        <= addr[1:0];
                        fault_q     <= 1'b0;
                        state_q     <= REQ;
                    end
                end
                REQ: begin
                    if (req_ready) begin
                        req_valid_q <= 1'b0;
                        state_q     <= WAIT;
                    end
                end
                WAIT: begin
                    if (rsp_valid) begin
                        if (!req_we_q) begin
                            rdata_q <= ld_data;
                        end
                        done_q  <= 1'b1;
                        fault_q <= 1'b0;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    // Core moves on this edge, so no re-issue check needed.
                    fault_q <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign stall     = access && (state_q != DONE);
    assign done      = done_q;
    assign fault     = fault_q;
    assign rdata     = rdata_q;
    assign req_valid = req_valid_q;
    assign req_we    = req_we_q;
    assign req_addr  = req_addr_q;
    assign req_wdata = req_wdata_q;
    assign req_wstrb = req_wstrb_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed self-checking bench for lsu_mem_stage.
// Inputs change and outputs are sampled 1ns after the rising edge.
module tb_lsu_mem_stage;
    import lsu_pkg::*;

    logic        clk;
    logic        reset;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        done;
    logic        fault;
    logic [31:0] rdata;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;

    int total;
    int bad;
    logic [31:0] last_rdata;

    lsu_mem_stage dut (
        .clk       (clk),
        .reset     (reset),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .funct3    (funct3),
        .addr      (addr),
        .wdata     (wdata),
        .stall     (stall),
        .done      (done),
        .fault     (fault),
        .rdata     (rdata),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        mem_read = 0; mem_write = 0; funct3 = 0;
        addr = 0; wdata = 0;
        req_ready = 1; rsp_valid = 1; rsp_rdata = 32'hFFFF_FFFF;
        step(); step();
        total++;
        if ({req_valid, done, fault, stall} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_ctl got=%b want=0000",
                     {req_valid, done, fault, stall});
        end
        total++;
        if ({rdata, req_addr, req_wdata, req_wstrb} !== '0) begin
            bad++;
            $display("FAIL reset_data got=%h %h %h %b want=0",
                     rdata, req_addr, req_wdata, req_wstrb);
        end
        reset = 1'b0;
        step();
        total++;
        if (stall !== 1'b0 || req_valid !== 1'b0) begin
            bad++;
            $display("FAIL idle_noaccess stall=%b rv=%b want=0 0",
                     stall, req_valid);
        end
    endtask

    task automatic test_store_byte();
        int stall_cnt;
        stall_cnt = 0;
        mem_write = 1; funct3 = F3_B;
        addr = 32'h0000_1003; wdata = 32'h0000_00AB;
        #1;
        if (stall === 1'b1) stall_cnt++;
        step();
        if (stall === 1'b1) stall_cnt++;
        total++;
        if (req_valid !== 1'b1 || req_we !== 1'b1 ||
            req_addr !== 32'h0000_1000 ||
            req_wdata !== 32'hABAB_ABAB || req_wstrb !== 4'b1000) begin
            bad++;
            $display("FAIL sb_req got v=%b we=%b a=%h d=%h s=%b want 1 1 00001000 abababab 1000",
                     req_valid, req_we, req_addr, req_wdata, req_wstrb);
        end
        step();
        if (stall === 1'b1) stall_cnt++;
        total++;
        if (req_valid !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL sb_wait rv=%b done=%b want=0 0", req_valid, done);
        end
        step();
        if (stall === 1'b1) stall_cnt++;
        total++;
        if (done !== 1'b1 || fault !== 1'b0) begin
            bad++;
            $display("FAIL sb_done done=%b fault=%b want=1 0", done, fault);
        end
        total++;
        if (stall_cnt != 3) begin
            bad++;
            $display("FAIL sb_stall_cycles got=%0d want=3", stall_cnt);
        end
        mem_write = 0;
        step();
        total++;
        if (done !== 1'b0 || stall !== 1'b0) begin
            bad++;
            $display("FAIL sb_retire done=%b stall=%b want=0 0", done, stall);
        end
    endtask

    task automatic test_store_half();
        mem_write = 1; funct3 = F3_H;
        addr = 32'h0000_3006; wdata = 32'h1234_ABCD;
        step();
        total++;
        if (req_addr !== 32'h0000_3004 ||
            req_wdata !== 32'hABCD_ABCD || req_wstrb !== 4'b1100) begin
            bad++;
            $display("FAIL sh_req a=%h d=%h s=%b want 00003004 abcdabcd 1100",
                     req_addr, req_wdata, req_wstrb);
        end
        step(); step();
        mem_write = 0;
        step();
    endtask

    task automatic test_loads();
        logic [2:0]  f3s [6] = '{F3_B, F3_BU, F3_H, F3_HU, F3_W, F3_B};
        logic [31:0] ads [6] = '{32'h2001, 32'h2001, 32'h2002,
                                 32'h2002, 32'h2000, 32'h2003};
        logic [31:0] rsp [6] = '{32'h1234_8056, 32'h1234_8056,
                                 32'h8001_ABCD, 32'h8001_ABCD,
                                 32'h1234_8056, 32'h1234_8056};
        logic [31:0] exp [6] = '{32'hFFFF_FF80, 32'h0000_0080,
                                 32'hFFFF_8001, 32'h0000_8001,
                                 32'h1234_8056, 32'h0000_0012};
        for (int i = 0; i < 6; i++) begin
            bit seen;
            seen = 0;
            mem_read = 1; funct3 = f3s[i]; addr = ads[i];
            rsp_rdata = rsp[i];
            step();
            if (i == 0) begin
                total++;
                if (req_we !== 1'b0 || req_wstrb !== 4'b0000 ||
                    req_addr !== 32'h0000_2000) begin
                    bad++;
                    $display("FAIL ld_req we=%b s=%b a=%h want 0 0000 00002000",
                             req_we, req_wstrb, req_addr);
                end
            end
            for (int c = 0; c < 10 && !seen; c++) begin
                if (done === 1'b1) seen = 1;
                else step();
            end
            total++;
            if (!seen) begin
                bad++;
                $display("FAIL ld%0d_timeout done never rose", i);
            end else if (rdata !== exp[i] || fault !== 1'b0) begin
                bad++;
                $display("FAIL ld%0d_data got=%h f=%b want=%h f=0",
                         i, rdata, fault, exp[i]);
            end
            mem_read = 0;
            rsp_rdata = 32'hDEAD_0000;
            step();
        end
        total++;
        if (rdata !== 32'h0000_0012) begin
            bad++;
            $display("FAIL ld_hold got=%h want=00000012", rdata);
        end
        last_rdata = 32'h0000_0012;
    endtask

    task automatic test_illegal();
        logic       rds [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic       wrs [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [2:0] f3s [5] = '{F3_W, F3_B, 3'b011, 3'b100, F3_H};
        logic [31:0] ads [5] = '{32'h2002, 32'h0, 32'h0, 32'h0, 32'h5};
        for (int i = 0; i < 5; i++) begin
            mem_read = rds[i]; mem_write = wrs[i];
            funct3 = f3s[i]; addr = ads[i];
            #1;
            total++;
            if (stall !== 1'b1 || req_valid !== 1'b0) begin
                bad++;
                $display("FAIL ill%0d_present stall=%b rv=%b want 1 0",
                         i, stall, req_valid);
            end
            step();
            total++;
            if (done !== 1'b1 || fault !== 1'b1 ||
                req_valid !== 1'b0 || stall !== 1'b0) begin
                bad++;
                $display("FAIL ill%0d_done d=%b f=%b rv=%b st=%b want 1 1 0 0",
                         i, done, fault, req_valid, stall);
            end
            mem_read = 0; mem_write = 0;
            step();
            total++;
            if (done !== 1'b0 || fault !== 1'b0) begin
                bad++;
                $display("FAIL ill%0d_clear d=%b f=%b want 0 0", i, done, fault);
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        ok = 1;
        req_ready = 0; rsp_valid = 0;
        mem_write = 1; funct3 = F3_W;
        addr = 32'h0000_0010; wdata = 32'hDEAD_BEEF;
        for (int c = 0; c < 4; c++) begin
            step();
            if (req_valid !== 1'b1 || req_we !== 1'b1 ||
                req_addr !== 32'h10 || req_wdata !== 32'hDEAD_BEEF ||
                req_wstrb !== 4'b1111 || stall !== 1'b1) begin
                ok = 0;
            end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL bp_hold v=%b a=%h d=%h s=%b st=%b want 1 10 deadbeef 1111 1",
                     req_valid, req_addr, req_wdata, req_wstrb, stall);
        end
        req_ready = 1;
        step();
        total++;
        if (req_valid !== 1'b0 || stall !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL bp_wait rv=%b st=%b d=%b want 0 1 0",
                     req_valid, stall, done);
        end
        rsp_rdata = 32'h5555_5555;
        step();
        total++;
        if (done !== 1'b0 || stall !== 1'b1) begin
            bad++;
            $display("FAIL bp_rsp_wait d=%b st=%b want 0 1", done, stall);
        end
        rsp_valid = 1;
        step();
        total++;
        if (done !== 1'b1 || fault !== 1'b0 || rdata !== last_rdata) begin
            bad++;
            $display("FAIL bp_done d=%b f=%b rdata=%h want 1 0 %h",
                     done, fault, rdata, last_rdata);
        end
        mem_write = 0;
        step();
    endtask

    task automatic test_reset_midflight();
        req_ready = 0; rsp_valid = 0;
        mem_read = 1; funct3 = F3_W; addr = 32'h40;
        step();
        total++;
        if (req_valid !== 1'b1) begin
            bad++;
            $display("FAIL rst_req_pre rv=%b want=1", req_valid);
        end
        #2;
        reset = 1; mem_read = 0;
        #1;
        total++;
        if (req_valid !== 1'b0 || dut.state_q !== IDLE) begin
            bad++;
            $display("FAIL rst_req_async rv=%b st=%0d want 0 0",
                     req_valid, dut.state_q);
        end
        step();
        reset = 0; req_ready = 1;
        rsp_rdata = 32'h7777_7777;
        mem_read = 1; funct3 = F3_W; addr = 32'h40;
        step(); step();
        total++;
        if (dut.state_q !== WAIT || stall !== 1'b1) begin
            bad++;
            $display("FAIL rst_wait_pre st=%0d stall=%b want 2 1",
                     dut.state_q, stall);
        end
        #2;
        reset = 1; mem_read = 0;
        #1;
        total++;
        if (req_valid !== 1'b0 || stall !== 1'b0 ||
            dut.state_q !== IDLE || rdata !== 32'h0) begin
            bad++;
            $display("FAIL rst_wait_async rv=%b st=%b s=%0d rd=%h want 0 0 0 0",
                     req_valid, stall, dut.state_q, rdata);
        end
        step();
        reset = 0;
        rsp_valid = 1;
        step(); step();
        total++;
        if (rdata !== 32'h0 || done !== 1'b0) begin
            bad++;
            $display("FAIL rst_late_rsp rd=%h d=%b want 0 0", rdata, done);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        last_rdata = '0;
        test_reset();
        test_store_byte();
        test_store_half();
        test_loads();
        test_illegal();
        test_backpressure();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
